// File: rtl/gearbox_request_arbiter_pkg.sv
// Shared definitions for the gearbox request arbiter: packet layout, widths
// and helper functions used to size ports and internal storage.
package gearbox_request_arbiter_pkg;

    localparam int LANES        = 4;
    localparam int META_W       = 128;
    localparam int GB_INT_WIDTH = 1;

    localparam logic [LANES-1:0] MASK_NONE = '0;

    // Packet layout at the default gearbox lane width; queues store the same
    // {mask, data, meta} ordering as a flat vector so other widths also work.
    typedef struct packed {
        logic [LANES-1:0]              mask;
        logic [LANES*GB_INT_WIDTH-1:0] data;
        logic [META_W-1:0]             meta;
    } packet_t;

    function automatic int req_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pkt_w(input int int_width);
        return LANES + LANES * int_width + META_W;
    endfunction

endpackage

// File: rtl/gearbox_request_arbiter_packet_queue.sv
// Small synchronous packet FIFO for one requester: drops on a full queue
// unless the same cycle also pops, with registered almost-full and sticky overflow.
module gearbox_packet_queue #(
    parameter int W            = 136,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] occ_o,
    output logic                   afull_o,
    output logic                   overflow_o
);
    localparam int AW       = $clog2(DEPTH);
    localparam int AFULL_TH = DEPTH - AFULL_MARGIN;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   occ_q;
    logic [AW:0]   occ_d;
    logic          afull_q;
    logic          overflow_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (occ_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (occ_q != '0);
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        occ_d = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            occ_d = occ_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            occ_q      <= '0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            occ_q   <= occ_d;
            afull_q <= (int'(occ_d) >= AFULL_TH);
            if (push_i && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o     = mem_q[rd_q];
    assign occ_o      = occ_q;
    assign afull_o    = afull_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/gearbox_request_arbiter.sv
// Merges N_REQ push-only gearbox outputs into one registered valid/ready
// stream using per-requester queues and a round-robin picker.
module gearbox_request_arbiter
    import gearbox_request_arbiter_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int INT_WIDTH    = 1,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ*LANES-1:0]           req_mask,
    input  logic [N_REQ*LANES*INT_WIDTH-1:0] req_data,
    input  logic [N_REQ*META_W-1:0]          req_meta,
    output logic [N_REQ-1:0]                 req_afull,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0]                 out_mask,
    output logic [LANES*INT_WIDTH-1:0]       out_data,
    output logic [META_W-1:0]                out_meta,
    output logic [req_id_w(N_REQ)-1:0]       out_src,
    output logic [N_REQ-1:0]                 overflow,
    output logic [N_REQ*32-1:0]              grant_cnt
);
    localparam int SW    = req_id_w(N_REQ);
    localparam int DW    = LANES * INT_WIDTH;
    localparam int PW    = pkt_w(INT_WIDTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0] nonempty;
    logic [N_REQ-1:0] pop;
    logic [PW-1:0]    head [N_REQ];
    logic             out_free;
    logic             grant_valid;
    logic [SW-1:0]    grant_id;

    logic             out_valid_q;
    logic [PW-1:0]    out_pkt_q;
    logic [SW-1:0]    last_q;

    assign out_free = !out_valid_q || out_ready;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [OCC_W-1:0] occ;
            logic [31:0]      cnt_q;

            gearbox_packet_queue #(
                .W            (PW),
                .DEPTH        (DEPTH),
                .AFULL_MARGIN (AFULL_MARGIN)
            ) u_queue (
                .clk         (clk),
                .rst         (rst),
                .push_i      (req_mask[LANES*gi +: LANES] != MASK_NONE),
                .push_data_i ({req_mask[LANES*gi +: LANES],
                               req_data[DW*gi +: DW],
                               req_meta[META_W*gi +: META_W]}),
                .pop_i       (pop[gi]),
                .head_o      (head[gi]),
                .occ_o       (occ),
                .afull_o     (req_afull[gi]),
                .overflow_o  (overflow[gi])
            );

            assign nonempty[gi] = (occ != '0);
            assign pop[gi]      = out_free && grant_valid && (grant_id == SW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (pop[gi]) begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end

            assign grant_cnt[32*gi +: 32] = cnt_q;
        end
    endgenerate

    // Scan from the requester after the last grant, wrapping modulo N_REQ.
    always_comb begin : pick
        logic [SW:0] cand;
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_q} + (SW+1)'(k);
            if (cand >= (SW+1)'(N_REQ)) begin
                cand = cand - (SW+1)'(N_REQ);
            end
            if (!grant_valid && nonempty[cand[SW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            last_q      <= '0;
        end else if (out_free) begin
            out_valid_q <= grant_valid;
            if (grant_valid) begin
                out_pkt_q <= head[grant_id];
                last_q    <= grant_id;
            end
        end
    end

    // The last grant is also the source of the packet currently held.
    assign out_valid                      = out_valid_q;
    assign {out_mask, out_data, out_meta} = out_pkt_q;
    assign out_src                        = last_q;

endmodule

// File: tb/tb_gearbox_request_arbiter.sv
// Randomized bench for gearbox_request_arbiter, checked every cycle against
// a queue-based behavioural model of the queues, picker and output register.
module tb_gearbox_request_arbiter;

    localparam int N      = 2;
    localparam int IW     = 1;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;
    localparam int DW     = 4 * IW;
    localparam int PW     = 4 + DW + 128;
    localparam int SW     = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [4*N-1:0]    req_mask;
    logic [DW*N-1:0]   req_data;
    logic [128*N-1:0]  req_meta;
    logic [N-1:0]      req_afull;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_mask;
    logic [DW-1:0]     out_data;
    logic [127:0]      out_meta;
    logic [SW-1:0]     out_src;
    logic [N-1:0]      overflow;
    logic [32*N-1:0]   grant_cnt;

    always #5 clk = ~clk;

    gearbox_request_arbiter #(
        .N_REQ        (N),
        .INT_WIDTH    (IW),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_mask  (req_mask),
        .req_data  (req_data),
        .req_meta  (req_meta),
        .req_afull (req_afull),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_data  (out_data),
        .out_meta  (out_meta),
        .out_src   (out_src),
        .overflow  (overflow),
        .grant_cnt (grant_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one queue per requester plus the output register.
    logic [PW-1:0] mq [N][$];
    logic          m_valid;
    logic [PW-1:0] m_pkt;
    int            m_last;
    logic [31:0]   m_cnt [N];
    logic [N-1:0]  m_ovf;
    logic [N-1:0]  m_afull;

    task automatic model_step(input logic r, input logic [4*N-1:0] m,
                              input logic [DW*N-1:0] d, input logic [128*N-1:0] mt,
                              input logic rdy);
        int g;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                m_cnt[i] = 0;
            end
            m_valid = 1'b0;
            m_pkt   = '0;
            m_last  = 0;
            m_ovf   = '0;
            m_afull = '0;
            return;
        end
        g = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_pkt   = mq[g].pop_front();
                m_valid = 1'b1;
                m_last  = g;
                m_cnt[g] = m_cnt[g] + 32'd1;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m[4*i +: 4] != 4'h0) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({m[4*i +: 4], d[DW*i +: DW], mt[128*i +: 128]});
                else m_ovf[i] = 1'b1;
            end
            m_afull[i] = (mq[i].size() >= DEPTH - MARGIN);
        end
    endtask

    task automatic cycle(input logic r, input logic [4*N-1:0] m, input logic rdy);
        logic [DW*N-1:0]  d;
        logic [128*N-1:0] mt;
        logic [32*N-1:0]  ecnt;
        for (int i = 0; i < N; i++) begin
            d[DW*i +: DW]    = DW'($urandom);
            mt[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
        rst = r; req_mask = m; req_data = d; req_meta = mt; out_ready = rdy;
        @(posedge clk);
        if (!r && m_valid && rdy)
            $display("xfer t=%0t src=%0d mask=%h data=%h", $time, m_last, m_pkt[PW-1 -: 4], m_pkt[127+DW -: DW]);
        model_step(r, m, d, mt, rdy);
        #1;
        for (int i = 0; i < N; i++) ecnt[32*i +: 32] = m_cnt[i];
        check_eq("out_valid", 256'(out_valid), 256'(m_valid));
        check_eq("out_src", 256'(out_src), 256'(m_last));
        check_eq("out_pkt", 256'({out_mask, out_data, out_meta}), 256'(m_pkt));
        check_eq("req_afull", 256'(req_afull), 256'(m_afull));
        check_eq("overflow", 256'(overflow), 256'(m_ovf));
        check_eq("grant_cnt", 256'(grant_cnt), 256'(ecnt));
    endtask

    initial begin
        m_valid = 1'b0; m_pkt = '0; m_last = 0; m_ovf = '0; m_afull = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset state, then single packet latency.
        repeat (3) cycle(1'b1, 8'h00, 1'b1);
        check_eq("rst_valid", 256'(out_valid), 256'(0));
        check_eq("rst_cnt", 256'(grant_cnt), 256'(0));
        cycle(1'b0, 8'h0F, 1'b1);
        check_eq("t1_not_yet", 256'(out_valid), 256'(0));
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("t1_valid", 256'(out_valid), 256'(1));
        check_eq("t1_mask", 256'(out_mask), 256'(4'hF));
        check_eq("t1_cnt0", 256'(grant_cnt[31:0]), 256'(1));
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // Both requesters pushing: strict alternation, no drops.
        repeat (6) cycle(1'b0, 8'hFF, 1'b1);
        repeat (10) cycle(1'b0, 8'h00, 1'b1);
        check_eq("t2_cnt", 256'(grant_cnt), 256'({32'd6, 32'd7}));
        check_eq("t2_ovf", 256'(overflow), 256'(0));

        // Output stalled with a held packet; requester 1 overfills its queue.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h0F, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) begin
            cycle(1'b0, 8'hF0, 1'b0);
            if (k == 1) check_eq("t3_afull", 256'(req_afull[1]), 256'(1));
        end
        check_eq("t3_ovf", 256'(overflow), 256'(2'b10));
        repeat (7) cycle(1'b0, 8'h00, 1'b1);
        check_eq("t3_cnt1", 256'(grant_cnt[63:32]), 256'(4));

        // Full queue, push and pop in the same cycle: accepted, no drop.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h0F, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        repeat (DEPTH) cycle(1'b0, 8'hF0, 1'b0);
        cycle(1'b0, 8'hF0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t4_ovf", 256'(overflow), 256'(0));
        repeat (8) cycle(1'b0, 8'h00, 1'b1);
        check_eq("t4_cnt1", 256'(grant_cnt[63:32]), 256'(5));

        // Partial and empty masks.
        cycle(1'b1, 8'h00, 1'b1);
        cycle(1'b0, 8'h03, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("t5_mask", 256'(out_mask), 256'(4'h3));
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("t5_empty", 256'(out_valid), 256'(0));

        // Mid-stream stall, then reset with packets still queued.
        repeat (4) cycle(1'b0, 8'hF3, 1'b1);
        repeat (3) cycle(1'b0, 8'h10, 1'b0);
        repeat (8) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        repeat (4) cycle(1'b0, 8'h0F, 1'b0);
        cycle(1'b1, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            check_eq("t6_flushed", 256'(out_valid), 256'(0));
        end

        // Random traffic with varying downstream pressure and rare resets.
        for (int n = 0; n < 1500; n++) begin
            logic [4*N-1:0] m;
            int ready_pct;
            ready_pct = (n / 250) % 3 == 0 ? 90 : ((n / 250) % 3 == 1 ? 40 : 70);
            for (int i = 0; i < N; i++)
                m[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            cycle($urandom_range(0, 299) == 0, m, $urandom_range(0, 99) < ready_pct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gearbox_request_arbiter.md
Name: gearbox_request_arbiter

Overview:
Shares one downstream memory-request FIFO port between N_REQ filter gearboxes, for example the instruction-cache and data-cache filters. Gearbox outputs are push-only and have no ready signal, so the block gives each requester a small packet queue and an almost-full backpressure flag. A round-robin arbiter selects among non-empty queues into a single registered valid/ready output. Drops and per-requester grant counts are exposed for debug.

Parameters:
N_REQ, 2, number of requesting gearboxes (2..8)
INT_WIDTH, 1, per-lane payload width (matches gearbox INT_WIDTH)
DEPTH, 4, packet entries per requester queue (power of 2, >=2)
AFULL_MARGIN, 2, req_afull asserts when occupancy >= DEPTH-AFULL_MARGIN

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_mask  in  N_REQ*4  lane-valid mask per requester; slice i = [4*i+:4]
req_data  in  N_REQ*4*INT_WIDTH  lane payload per requester
req_meta  in  N_REQ*128  lane metadata per requester (4x32)
req_afull  out  N_REQ  queue i almost full; gearbox i must flush/stall
out_valid  out  1  output packet valid
out_ready  in  1  downstream accepts
out_mask  out  4  lane mask of output packet
out_data  out  4*INT_WIDTH  payload
out_meta  out  128  metadata
out_src  out  $clog2(N_REQ)  requester id of output packet
overflow  out  N_REQ  sticky: packet dropped on full queue
grant_cnt  out  N_REQ*32  packets granted per requester, wraps

Behaviour:
- Reset values: all queues empty, out_valid=0, out_mask=0, out_data=0, out_meta=0, out_src=0, overflow=0, grant_cnt=0, rr pointer=0, req_afull=0.
- Push: the queue push for requester i occurs when req_mask[i] != 0. The packet stored is {mask, data, meta}. A mask of 0 is never queued.
- Full queue:
  - A push to a full queue with no same-cycle pop is dropped. overflow[i] is set and stays set until rst.
  - A push to a full queue that is popped in the same cycle is accepted, and occupancy is unchanged.
- Occupancy width is $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- req_afull[i] is registered and reflects occupancy after the current update.
- Output register "free" = !out_valid || out_ready.
- Arbitration, every cycle the output register is free:
  - Scan requesters starting at (last_grant+1) mod N_REQ. Grant the first non-empty queue.
  - Pop that queue, load the output register, set out_src and out_valid=1, set last_grant to the granted id, and increment grant_cnt[id].
  - If no queue is non-empty, clear out_valid and leave the payload registers unchanged.
- Hold: while out_valid && !out_ready, all out_* signals are stable and no pop occurs.
- Latency: a packet pushed at edge E into an empty system with free output appears with out_valid=1 after edge E+1. Full throughput is 1 packet/cycle with out_ready held high.
- Fairness: with all queues continuously non-empty, grants rotate strictly 0,1,...,N_REQ-1. No requester waits more than N_REQ-1 grants.
- Partial masks, such as idle-flush packets, are passed through unaltered. Lane order is preserved.
- rst mid-operation: all state clears on the next edge, and queued packets are discarded without output.
- grant_cnt wraps from 2^32-1 to 0.

Decomposition:
- Shared package: packet struct {mask[3:0], data[4*INT_WIDTH], meta[127:0]}, a REQ_ID_W localparam function, and the MASK_NONE constant.
- One sub-module: gearbox_packet_queue, a synchronous FIFO with push/pop/occupancy/afull/overflow, instantiated N_REQ times.
- The round-robin picker stays inline.

Test Plan:
1. Reset, then req_mask[0]=4'b1111 for one cycle with out_ready=1 -> out_valid=1 two edges later, out_src=0, out_mask=4'hf, data/meta match, grant_cnt[0]=1.
2. Both requesters push 4'hf for 8 cycles, out_ready=1 -> out_src alternates 0,1,0,1... over 16 packets; final grant_cnt = {8,8}; no overflow.
3. out_ready=0, requester 1 pushes DEPTH+1=5 packets -> req_afull[1]=1 after 2nd push, overflow[1]=1 after 5th, occupancy 4; releasing out_ready yields exactly 4 packets in order.
4. Queue full plus push plus out_ready pulse in same cycle -> push accepted, overflow stays 0, 5 packets total emerge.
5. Partial mask 4'b0011 from requester 0 -> out_mask=4'b0011, lanes 2-3 data passed unchanged. Mask 4'b0000 -> nothing queued.
6. out_ready stalled for 3 cycles mid-stream -> out_* stable across the stall. Asserting rst with 3 queued packets -> out_valid=0 next cycle, none emitted afterwards.
